// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage: splits and classifies a 32-bit word, then holds the
// decoded result in an output register backed by a one-entry skid buffer.
module id_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [5:0]       o_opcode,
    output logic [4:0]       o_RS,
    output logic [4:0]       o_RT,
    output logic [4:0]       o_RD,
    output logic [4:0]       o_shamt,
    output logic [5:0]       o_funct,
    output logic [15:0]      o_address,
    output logic [XLEN-1:0]  o_imm_ext,
    output logic [25:0]      o_jump_target,
    output logic [1:0]       o_type,
    output logic [4:0]       o_dest,
    output logic             o_reg_write,
    output logic [PC_W-1:0]  o_pc,
    output logic [CNT_W-1:0] o_decode_count
);

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [15:0]     address;
        logic [XLEN-1:0] imm_ext;
        logic [25:0]     jump_target;
        logic [1:0]      itype;
        logic [4:0]      dest;
        logic            reg_write;
        logic [PC_W-1:0] pc;
    } dec_t;

    dec_t             dec;
    dec_t             out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept, drain;
    logic signed [31:0] lui_word;
    logic signed [15:0] imm_s;

    always_comb begin
        dec             = '0;
        dec.opcode      = i_instruction[31:26];
        dec.rs          = i_instruction[25:21];
        dec.rt          = i_instruction[20:16];
        dec.rd          = i_instruction[15:11];
        dec.shamt       = i_instruction[10:6];
        dec.funct       = i_instruction[5:0];
        dec.address     = i_instruction[15:0];
        dec.jump_target = i_instruction[25:0];
        dec.pc          = i_pc;
        imm_s           = i_instruction[15:0];
        lui_word        = {i_instruction[15:0], 16'h0000};

        case (dec.opcode)
            6'h0C, 6'h0D, 6'h0E: dec.imm_ext = XLEN'(dec.address);
            6'h0F:               dec.imm_ext = XLEN'(lui_word);
            default:             dec.imm_ext = XLEN'(imm_s);
        endcase

        case (dec.opcode)
            6'h00: begin
                dec.itype     = 2'd0;
                dec.dest      = dec.rd;
                dec.reg_write = (dec.funct != 6'h08);
            end
            6'h02: begin
                dec.itype     = 2'd2;
                dec.dest      = 5'd0;
                dec.reg_write = 1'b0;
            end
            6'h03: begin
                dec.itype     = 2'd2;
                dec.dest      = 5'd31;
                dec.reg_write = 1'b1;
            end
            default: begin
                dec.itype     = 2'd1;
                dec.dest      = dec.rt;
                // Stores and branches produce no register result.
                dec.reg_write = !(dec.opcode inside {6'h28, 6'h29, 6'h2B,
                                                     6'h04, 6'h05, 6'h06, 6'h07});
            end
        endcase
    end

    assign accept = i_valid && ready_q && !i_flush;
    assign drain  = out_valid_q && i_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        count_d      = drain ? count_q + 1'b1 : count_q;

        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain || !out_valid_q) begin
            // SKID is only ever full while OUT is full, and accept is blocked then.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            count_q      <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            count_q      <= count_d;
        end
    end

    assign o_ready        = ready_q;
    assign o_valid        = out_valid_q;
    assign o_opcode       = out_q.opcode;
    assign o_RS           = out_q.rs;
    assign o_RT           = out_q.rt;
    assign o_RD           = out_q.rd;
    assign o_shamt        = out_q.shamt;
    assign o_funct        = out_q.funct;
    assign o_address      = out_q.address;
    assign o_imm_ext      = out_q.imm_ext;
    assign o_jump_target  = out_q.jump_target;
    assign o_type         = out_q.itype;
    assign o_dest         = out_q.dest;
    assign o_reg_write    = out_q.reg_write;
    assign o_pc           = out_q.pc;
    assign o_decode_count = count_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomised and directed bench for id_decode_stage; a queue of accepted words models
// the two-entry store and the reference decode is recomputed arithmetically per output.
module tb_id_decode_stage;
    localparam int XLEN  = 64;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_reset, i_valid, i_flush, i_ready;
    logic [31:0]      i_instruction;
    logic [PC_W-1:0]  i_pc;
    logic             o_ready, o_valid, o_reg_write;
    logic [5:0]       o_opcode, o_funct;
    logic [4:0]       o_RS, o_RT, o_RD, o_shamt, o_dest;
    logic [15:0]      o_address;
    logic [XLEN-1:0]  o_imm_ext;
    logic [25:0]      o_jump_target;
    logic [1:0]       o_type;
    logic [PC_W-1:0]  o_pc;
    logic [CNT_W-1:0] o_decode_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] q_ins[$];
    logic [31:0] q_pc[$];
    int unsigned handoffs = 0;

    id_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode), .o_RS(o_RS),
        .o_RT(o_RT), .o_RD(o_RD), .o_shamt(o_shamt), .o_funct(o_funct),
        .o_address(o_address), .o_imm_ext(o_imm_ext), .o_jump_target(o_jump_target),
        .o_type(o_type), .o_dest(o_dest), .o_reg_write(o_reg_write), .o_pc(o_pc),
        .o_decode_count(o_decode_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_out();
        longint unsigned w, op, rs, rt, rd, fn, imm, e, ty, de, wr;
        check("valid", 64'(o_valid), 64'(q_ins.size() > 0));
        check("ready", 64'(o_ready), 64'(q_ins.size() <= 1));
        check("count", 64'(o_decode_count), 64'(handoffs % 16));
        if (q_ins.size() > 0) begin
            w   = 64'(q_ins[0]);
            op  = w / (1 << 26);
            rs  = (w / (1 << 21)) % 32;
            rt  = (w / (1 << 16)) % 32;
            rd  = (w / (1 << 11)) % 32;
            fn  = w % 64;
            imm = w % 65536;
            if (op >= 12 && op <= 14) e = imm;
            else if (op == 15) begin
                e = imm * 65536;
                if (e >= 64'h8000_0000) e = e + 64'hFFFF_FFFF_0000_0000;
            end else e = (imm >= 32768) ? imm + 64'hFFFF_FFFF_FFFF_0000 : imm;
            ty = (op == 0) ? 0 : ((op == 2 || op == 3) ? 2 : 1);
            de = (op == 0) ? rd : (op == 3) ? 31 : (op == 2) ? 0 : rt;
            wr = ((op == 0 && fn == 8) || op == 2 || op == 40 || op == 41 || op == 43 ||
                  (op >= 4 && op <= 7)) ? 0 : 1;
            check("opcode", 64'(o_opcode), op);
            check("rs", 64'(o_RS), rs);
            check("rt", 64'(o_RT), rt);
            check("rd", 64'(o_RD), rd);
            check("shamt", 64'(o_shamt), (w / 64) % 32);
            check("funct", 64'(o_funct), fn);
            check("address", 64'(o_address), imm);
            check("imm_ext", o_imm_ext, e);
            check("jump_target", 64'(o_jump_target), w % (1 << 26));
            check("type", 64'(o_type), ty);
            check("dest", 64'(o_dest), de);
            check("reg_write", 64'(o_reg_write), wr);
            check("pc", 64'(o_pc), 64'(q_pc[0]));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic fl, input logic rst);
        logic [31:0] pc;
        bit acc, drn;
        pc = $urandom;
        i_valid = v; i_instruction = ins; i_pc = pc;
        i_ready = rdy; i_flush = fl; i_reset = rst;
        acc = v && (q_ins.size() <= 1) && !fl;
        drn = (q_ins.size() > 0) && rdy;
        if (rst) begin
            q_ins.delete(); q_pc.delete(); handoffs = 0;
        end else begin
            if (drn) begin
                $display("xfer %0d: pc=0x%08h instr=0x%08h", handoffs, q_pc[0], q_ins[0]);
                handoffs++;
                void'(q_ins.pop_front()); void'(q_pc.pop_front());
            end
            if (fl) begin
                q_ins.delete(); q_pc.delete();
            end else if (acc) begin
                q_ins.push_back(ins); q_pc.push_back(pc);
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        compare_out();
    endtask

    task automatic check_reset_state();
        check("rst_valid", 64'(o_valid), 0);
        check("rst_ready", 64'(o_ready), 1);
        check("rst_count", 64'(o_decode_count), 0);
        check("rst_opcode", 64'(o_opcode), 0);
        check("rst_fields", 64'({o_RS, o_RT, o_RD, o_shamt, o_funct}), 0);
        check("rst_imm", o_imm_ext, 0);
        check("rst_misc", 64'({o_address, o_jump_target, o_type, o_dest, o_reg_write}), 0);
        check("rst_pc", 64'(o_pc), 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09,
                                  6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h28, 6'h2B};
        logic [31:0] r;
        logic [31:0] w;
        r = $urandom;
        if ($urandom_range(3) == 0) return r;
        w = {ops[$urandom_range(14)], r[25:0]};
        if (w[31:26] == 6'h00 && $urandom_range(2) == 0) w[5:0] = 6'h08;
        return w;
    endfunction

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_instruction = '0; i_pc = '0;
        @(negedge i_clk);
        step(0, 0, 0, 0, 1);
        check_reset_state();

        step(1, 32'h00221820, 1, 0, 0);
        check("add_rs", 64'(o_RS), 1); check("add_rt", 64'(o_RT), 2);
        check("add_rd", 64'(o_RD), 3); check("add_funct", 64'(o_funct), 64'h20);
        check("add_type", 64'(o_type), 0); check("add_dest", 64'(o_dest), 3);
        check("add_wr", 64'(o_reg_write), 1);
        step(1, 32'h03E00008, 1, 0, 0); check("jr_wr", 64'(o_reg_write), 0);
        step(1, 32'h2008FFFF, 1, 0, 0);
        check("addi_imm", o_imm_ext, 64'hFFFF_FFFF_FFFF_FFFF); check("addi_dest", 64'(o_dest), 8);
        step(1, 32'h3508FFFF, 1, 0, 0); check("ori_imm", o_imm_ext, 64'h0000_FFFF);
        step(1, 32'h3C011234, 1, 0, 0); check("lui_imm", o_imm_ext, 64'h1234_0000);
        step(1, 32'hAC280004, 1, 0, 0); check("sw_wr", 64'(o_reg_write), 0);
        step(1, 32'h0C100000, 1, 0, 0);
        check("jal_type", 64'(o_type), 2); check("jal_target", 64'(o_jump_target), 64'h0100000);
        check("jal_dest", 64'(o_dest), 31); check("jal_wr", 64'(o_reg_write), 1);
        step(1, 32'h08100000, 1, 0, 0);
        check("j_dest", 64'(o_dest), 0); check("j_wr", 64'(o_reg_write), 0);
        step(0, 0, 1, 0, 0);

        // Backpressure: A to OUT, B to SKID, C held until space frees.
        step(0, 0, 0, 0, 1);
        step(1, 32'h2001000A, 0, 0, 0); check("bp_ready_a", 64'(o_ready), 1);
        step(1, 32'h2002000B, 0, 0, 0); check("bp_ready_b", 64'(o_ready), 0);
        step(1, 32'h2003000C, 0, 0, 0); check("bp_ready_c", 64'(o_ready), 0);
        step(1, 32'h2003000C, 1, 0, 0);
        step(1, 32'h2003000C, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("bp_count", 64'(o_decode_count), 3);

        // Flush with both entries full and a valid input.
        step(0, 0, 0, 0, 1);
        step(1, 32'h20010001, 0, 0, 0);
        step(1, 32'h20020002, 0, 0, 0);
        step(1, 32'h20030003, 0, 1, 0);
        check("fl_valid", 64'(o_valid), 0); check("fl_ready", 64'(o_ready), 1);
        check("fl_count", 64'(o_decode_count), 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("fl_after", 64'(o_valid), 0);

        // Counter wrap with a 4-bit counter.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, rand_instr(), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("wrap_count", 64'(o_decode_count), 1);

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) step(1, rand_instr(), 1'($urandom_range(1)), 0, 0);
        step(1, rand_instr(), 1, 0, 1);
        check_reset_state();

        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(3) != 0), rand_instr(), 1'($urandom_range(2) != 0),
                 1'($urandom_range(24) == 0), 1'($urandom_range(99) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
